// File: rtl/shot_tracker.sv
// rtl/shot_tracker.sv - per-round shot, hit and BCD score bookkeeping; optional SHOT_DEBOUNCE_EN click debounce
module shot_tracker #(
    parameter int MAX_SHOTS       = 3,
    parameter int FLASH_FRAMES    = 8,
    parameter int SCORE_DIGITS    = 4,
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic                      Clk,
    input  logic                      Reset_n,
    input  logic                      frame_clk,
    input  logic                      round_start,
    input  logic                      click,
    input  logic                      duck_active,
    input  logic                      cursor_over_duck,
    output logic                      shot,
    output logic [1:0]                num_shots,
    output logic                      bird_shot,
    output logic                      round_over,
    output logic [4*SCORE_DIGITS-1:0] score_bcd
);

    typedef enum logic [1:0] {IDLE, ARMED, FLASH, DONE} state_t;

    state_t                    state_q, state_d;
    logic                      sync1_q, sync2_q, prev_q, edge_q, frame_q;
    logic                      click_lvl, click_edge, tick, hit;
    logic [1:0]                num_q, num_d;
    logic                      bird_q, bird_d;
    logic [7:0]                cnt_q, cnt_d;
    logic [4*SCORE_DIGITS-1:0] score_q, score_d, score_inc;
    logic                      carry, all_nine;

    if (MAX_SHOTS < 1 || MAX_SHOTS > 3 || FLASH_FRAMES < 1 || FLASH_FRAMES > 255
        || DEBOUNCE_CYCLES < 1) begin : g_bad_param
        $error("shot_tracker: parameter out of range");
    end

`ifdef SHOT_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    logic [DW-1:0] db_cnt_q;
    logic          db_q;

    // Level rises on the DEBOUNCE_CYCLES-th consecutive high sample; any low clears it.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else if (!sync2_q) begin
            db_cnt_q <= '0;
            db_q     <= 1'b0;
        end else begin
            if (db_cnt_q != DW'(DEBOUNCE_CYCLES)) db_cnt_q <= db_cnt_q + 1'b1;
            if (db_cnt_q >= DW'(DEBOUNCE_CYCLES - 1)) db_q <= 1'b1;
        end
    end
    assign click_lvl = db_q;
`else
    assign click_lvl = sync2_q;
`endif

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            edge_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            sync1_q <= click;
            sync2_q <= sync1_q;
            prev_q  <= click_lvl;
            edge_q  <= click_lvl & ~prev_q;
            frame_q <= frame_clk;
        end
    end

    assign click_edge = edge_q;
    assign tick       = frame_clk & ~frame_q;
    assign hit        = duck_active & cursor_over_duck;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            num_q   <= '0;
            bird_q  <= 1'b0;
            cnt_q   <= '0;
            score_q <= '0;
        end else begin
            state_q <= state_d;
            num_q   <= num_d;
            bird_q  <= bird_d;
            cnt_q   <= cnt_d;
            score_q <= score_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (round_start) state_d = ARMED;
            ARMED: begin
                if (round_start)     state_d = ARMED;
                else if (click_edge) state_d = FLASH;
            end
            FLASH: begin
                if (round_start) state_d = ARMED;
                else if (tick && cnt_q == 8'd1)
                    state_d = (bird_q || num_q == 2'(MAX_SHOTS)) ? DONE : ARMED;
            end
            DONE:  if (round_start) state_d = ARMED;
            default: state_d = IDLE;
        endcase
    end

    // Ripple +1 across digits; an all-nines score is held rather than wrapped.
    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        all_nine  = 1'b1;
        for (int i = 0; i < SCORE_DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) all_nine = 1'b0;
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        if (all_nine) score_inc = score_q;
    end

    always_comb begin
        num_d   = num_q;
        bird_d  = bird_q;
        cnt_d   = cnt_q;
        score_d = score_q;
        if (round_start) begin
            num_d  = '0;
            bird_d = 1'b0;
            cnt_d  = '0;
        end else if (state_q == ARMED && click_edge) begin
            num_d = num_q + 2'd1;
            cnt_d = 8'(FLASH_FRAMES);
            if (hit) begin
                bird_d  = 1'b1;
                score_d = score_inc;
            end
        end else if (state_q == FLASH && tick) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    always_comb begin
        shot       = (state_q == FLASH);
        round_over = (state_q == DONE);
        num_shots  = num_q;
        bird_shot  = bird_q;
        score_bcd  = score_q;
    end

endmodule

// File: tb/tb_shot_tracker.sv
// tb/tb_shot_tracker.sv - self-checking bench for shot_tracker against a round-level model
module tb_shot_tracker;

    logic        Clk = 1'b0;
    logic        Reset_n, frame_clk, round_start, click, duck_active, cursor_over_duck;
    logic        shot, bird_shot, round_over;
    logic [1:0]  num_shots;
    logic [15:0] score_bcd;

    int errors = 0;
    int checks = 0;

    // Model: 0 idle, 1 armed, 2 flashing, 3 round over; score kept as a plain integer.
    int mstate, mnum, mleft, mscore;
    bit mbird;

    shot_tracker dut (
        .Clk(Clk), .Reset_n(Reset_n), .frame_clk(frame_clk), .round_start(round_start),
        .click(click), .duck_active(duck_active), .cursor_over_duck(cursor_over_duck),
        .shot(shot), .num_shots(num_shots), .bird_shot(bird_shot),
        .round_over(round_over), .score_bcd(score_bcd)
    );

    always #5 Clk = ~Clk;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int t;
        t = v;
        for (int i = 0; i < 4; i++) begin
            r[4*i +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".shot"},       16'(shot),       16'(mstate == 2));
        chk({tag, ".num_shots"},  16'(num_shots),  16'(mnum));
        chk({tag, ".bird_shot"},  16'(bird_shot),  16'(mbird));
        chk({tag, ".round_over"}, 16'(round_over), 16'(mstate == 3));
        chk({tag, ".score"},      score_bcd,       to_bcd(mscore));
    endtask

    task automatic start_round();
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        mstate = 1; mnum = 0; mbird = 0;
    endtask

    task automatic do_click(input bit da, input bit co);
        duck_active = da;
        cursor_over_duck = co;
        click = 1'b1;
        repeat (4) step();
        click = 1'b0;
        repeat (3) step();
        duck_active = 1'b0;
        cursor_over_duck = 1'b0;
        if (mstate == 1) begin
            mnum++;
            if (da && co) begin
                mbird = 1;
                if (mscore < 9999) mscore++;
            end
            mstate = 2;
            mleft  = 8;
        end
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1;
            step();
            frame_clk = 1'b0;
            step();
            if (mstate == 2) begin
                mleft--;
                if (mleft == 0) mstate = (mbird || mnum == 3) ? 3 : 1;
            end
        end
    endtask

    // One hit every three cycles: each round_start aborts the previous flash before the next click lands.
    task automatic fast_hits(input int n);
        duck_active = 1'b1;
        cursor_over_duck = 1'b1;
        for (int i = 0; i < n; i++) begin
            click = 1'b1;
            step();
            click = 1'b0;
            round_start = 1'b1;
            step();
            round_start = 1'b0;
            step();
        end
        repeat (2) step();
        duck_active = 1'b0;
        cursor_over_duck = 1'b0;
        mscore = (mscore + n > 9999) ? 9999 : mscore + n;
        mstate = 2; mnum = 1; mbird = 1; mleft = 8;
        repeat (2) step();
    endtask

    initial begin
        Reset_n = 1'b0; frame_clk = 1'b0; round_start = 1'b0; click = 1'b0;
        duck_active = 1'b0; cursor_over_duck = 1'b0;
        mstate = 0; mnum = 0; mleft = 0; mscore = 0; mbird = 0;
        repeat (2) step();
        check_all("reset");
        Reset_n = 1'b1;
        step();

        // Missed click with exact latency and flash length.
        start_round();
        check_all("armed");
        click = 1'b1;
        repeat (3) step();
        chk("lat.shot_early", 16'(shot), 16'd0);
        step();
        chk("lat.shot", 16'(shot), 16'd1);
        chk("lat.num", 16'(num_shots), 16'd1);
        click = 1'b0;
        repeat (3) step();
        mstate = 2; mnum = 1; mleft = 8;
        frames(7);
        chk("flash7.shot", 16'(shot), 16'd1);
        frames(1);
        check_all("miss1");

        do_click(0, 0); frames(8);
        do_click(1, 0); frames(8);
        check_all("miss3");
        do_click(0, 0);
        check_all("click_in_done");

        // Click during flash, then click colliding with round_start.
        start_round();
        check_all("restart");
        do_click(0, 1);
        do_click(0, 0);
        check_all("click_in_flash");
        frames(8);
        click = 1'b1;
        repeat (3) step();
        round_start = 1'b1;
        step();
        round_start = 1'b0;
        click = 1'b0;
        repeat (3) step();
        mstate = 1; mnum = 0; mbird = 0;
        check_all("click_vs_start");

        // BCD carry 9 -> 10.
        fast_hits(9);
        start_round();
        check_all("score9");
        do_click(1, 1);
        check_all("hit_carry");
        frames(8);
        check_all("hit_done");

        // Randomized rounds.
        for (int r = 0; r < 5; r++) begin
            start_round();
            for (int s = 0; s < 4; s++) begin
                do_click(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                check_all("rnd.click");
                frames(8);
                check_all("rnd.flash_end");
                if (mstate == 3) break;
            end
        end

        // Saturation at 9999.
        fast_hits(9998 - mscore);
        start_round();
        check_all("score9998");
        do_click(1, 1);
        check_all("hit_9999");
        start_round();
        do_click(1, 1);
        check_all("hit_saturate");

        // Asynchronous reset mid-flash.
        start_round();
        do_click(0, 0);
        frames(3);
        check_all("pre_reset");
        #2 Reset_n = 1'b0;
        #1;
        mstate = 0; mnum = 0; mbird = 0; mscore = 0;
        check_all("async_reset");
        step();
        Reset_n = 1'b1;
        frames(8);
        check_all("post_reset");
        start_round();
        check_all("post_reset_round");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/shot_tracker.md
Name: shot_tracker

Overview:
- Per-round shot bookkeeping stage directly upstream of color_mapper; drives its shot, num_shots and bird_shot inputs, plus a BCD score for the score sprite address logic.
- Synchronises the mouse button and detects click edges.
- Judges each click as hit or miss from the cursor-over-duck flag.
- Holds a muzzle-flash window for a fixed number of frames, counts shots against a per-round limit and accumulates hits into a saturating BCD score.

Parameters:
- MAX_SHOTS, 3: shots allowed per round (1..3).
- FLASH_FRAMES, 8: frames the shot flag stays high after a click (1..255).
- SCORE_DIGITS, 4: BCD digits in the score.
- DEBOUNCE_CYCLES, 16: stable-high Clk cycles needed when SHOT_DEBOUNCE_EN is defined.

Ports:
- Clk, input, 1: system clock.
- Reset_n, input, 1: asynchronous active-low reset.
- frame_clk, input, 1: vertical-sync level, synchronous to Clk; each rising edge is one frame tick.
- round_start, input, 1: one-cycle pulse that begins a new round.
- click, input, 1: raw mouse left-button level, asynchronous.
- duck_active, input, 1: duck is alive and on screen.
- cursor_over_duck, input, 1: cursor currently overlaps a duck pixel.
- shot, output, 1: flash window active.
- num_shots, output, 2: shots fired this round (0..MAX_SHOTS).
- bird_shot, output, 1: duck hit this round; sticky.
- round_over, output, 1: round finished, waiting for round_start.
- score_bcd, output, 4*SCORE_DIGITS: packed BCD score, digit 0 in the LSBs.

Behaviour:
- Reset (async, Reset_n low): all outputs 0, score_bcd 0, FSM to IDLE, synchroniser and edge registers 0.
- Click path: 2-flop synchroniser feeds an edge register; click_edge = sync & ~prev.
  - If raw click is first captured at edge k, click_edge is high in cycle k+2.
  - shot and num_shots update at edge k+3.
- Frame tick: frame_clk registered once; tick = frame_clk & ~frame_q.
- FSM states: IDLE, ARMED, FLASH, DONE.
  - IDLE: entered from reset; outputs quiet; round_start -> ARMED.
  - ARMED, on click_edge:
    - shot<=1, num_shots<=num_shots+1, flash counter<=FLASH_FRAMES, go to FLASH.
    - If duck_active & cursor_over_duck in the click_edge cycle: bird_shot<=1 and score += 1 (BCD).
  - FLASH: counter decrements on each tick. When it reaches 0, shot<=0, then:
    - go to DONE if bird_shot=1 or num_shots=MAX_SHOTS;
    - otherwise return to ARMED.
  - DONE: round_over=1. round_start -> ARMED with num_shots<=0, bird_shot<=0, round_over<=0. score_bcd is kept across rounds.
- round_start in any non-IDLE state: restart the round the same way as from DONE. shot<=0; any flash in progress is aborted.
- Precedence:
  - round_start beats click_edge in the same cycle; the click is discarded.
  - Clicks in IDLE, FLASH or DONE are ignored and do not consume a shot.
- BCD increment:
  - Digit-wise carry: a digit at 9 becomes 0 and carries into the next digit.
  - Saturation: when every digit is 9, score holds at all-9s and does not wrap.
- Each hit adds exactly one point; a second hit in the same round is impossible because the FSM goes to DONE.
- Reset asserted mid-flash: immediate return to the reset values; no residual flash after Reset_n deasserts.

Optional Feature:
- Macro: SHOT_DEBOUNCE_EN.
- Defined: a counter behind the synchroniser must see DEBOUNCE_CYCLES consecutive high samples before the debounced level rises. Lows clear the counter. click_edge is taken from the debounced level, adding DEBOUNCE_CYCLES cycles of latency; glitches shorter than DEBOUNCE_CYCLES never fire a shot.
- Undefined: click_edge is taken directly from the 2-flop synchroniser with the latency above; no counter logic is present.

Test Plan:
- Reset, round_start, one click with cursor_over_duck=0 -> shot=1 and num_shots=1 at click+3 cycles, bird_shot=0. shot falls after exactly 8 frame ticks. FSM returns to ARMED.
- Three missed clicks, each after its flash ends -> num_shots=3. After the third flash, round_over=1; a fourth click leaves num_shots=3 and shot=0.
- Hit with duck_active=1, cursor_over_duck=1, score starting at 0x0009 -> bird_shot=1, score_bcd=0x0010. round_over=1 after the flash.
- Click during FLASH and click in the same cycle as round_start -> neither changes num_shots. round_start resets num_shots=0 and bird_shot=0 while score is kept.
- Score preloaded to 0x9999 via repeated hits, then another hit -> score_bcd stays 0x9999. Reset_n pulsed mid-flash -> all outputs 0 asynchronously.
- With SHOT_DEBOUNCE_EN: a 10-cycle click glitch -> no shot. A 20-cycle press -> shot at click+2+16+1 cycles.
